// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: instruction-memory port, decode handshake and branch redirect.
// master = fetch controller, slave = memory/decode/execute side.
interface instr_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, delivers words to decode over valid/ready,
// folds unconditional jumps in fetch, takes branch redirects and stops on a halt word.
module instr_fetch_ctrl #(
  parameter int unsigned       ADDR_W    = 6,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  instr_fetch_ctrl_if.master  bus,
  output logic                halted,
  output logic [15:0]         fetch_count
);

  localparam logic [5:0] OP_JUMP = 6'b000111;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [DATA_W-1:0] out_instr_q, out_instr_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       fetch_count_q, fetch_count_d;
  logic              handshake;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_pc_d      = out_pc_q;
    out_instr_d   = out_instr_q;
    out_valid_d   = out_valid_q;
    fetch_count_d = fetch_count_q;
    handshake     = out_valid_q && bus.out_ready;

    // A handshake counts even when a redirect flushes the same cycle.
    if (handshake && (fetch_count_q != '1)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end

    if ((state_q != S_IDLE) && bus.redirect_valid) begin
      state_d     = S_FETCH;
      pc_d        = bus.redirect_pc;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
            pc_d    = RESET_PC;
          end
        end
        S_FETCH: begin
          if (!out_valid_q || bus.out_ready) begin
            if (bus.imem_data == HALT_WORD) begin
              state_d     = S_HALT;
              out_valid_d = 1'b0;
            end else begin
              out_instr_d = bus.imem_data;
              out_pc_d    = pc_q;
              out_valid_d = 1'b1;
              if (bus.imem_data[DATA_W-1 -: 6] == OP_JUMP) begin
                pc_d = bus.imem_data[ADDR_W-1:0];
              end else begin
                pc_d = pc_q + ADDR_W'(1);
              end
            end
          end
        end
        S_HALT: begin
          out_valid_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      out_pc_q      <= '0;
      out_instr_q   <= '0;
      out_valid_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_pc_q      <= out_pc_d;
      out_instr_q   <= out_instr_d;
      out_valid_q   <= out_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign halted        = (state_q == S_HALT);
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: per-cycle vector table plus a scoreboard of delivered words.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halted;
  logic [15:0] fetch_count;
  logic [31:0] mem [64];

  instr_fetch_ctrl_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  instr_fetch_ctrl #(
    .ADDR_W   (6),
    .DATA_W   (32),
    .RESET_PC (6'd0),
    .HALT_WORD(32'h00000000)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .halted     (halted),
    .fetch_count(fetch_count)
  );

  assign bus.imem_data = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic        st;
    logic        rdy;
    logic        rv;
    logic [5:0]  rpc;
    logic        e_v;
    logic [5:0]  e_pc;
    logic [5:0]  e_addr;
    logic        e_h;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [5:0]  pc;
    logic [31:0] instr;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  function automatic void add(input logic st, input logic rdy, input logic rv,
                              input int rpc, input logic e_v, input int e_pc,
                              input int e_addr, input logic e_h, input int e_cnt);
    vec_t v;
    v.st = st; v.rdy = rdy; v.rv = rv; v.rpc = 6'(rpc);
    v.e_v = e_v; v.e_pc = 6'(e_pc); v.e_addr = 6'(e_addr); v.e_h = e_h;
    v.e_cnt = 16'(e_cnt);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every handshake must match the next expected delivery.
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL sb_unexpected: got pc %0d expected no delivery", bus.out_pc);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_pc", 32'(bus.out_pc), 32'(e.pc));
        chk("sb_instr", bus.out_instr, e.instr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h04001000 + 32'(i);
    mem[0]  = 32'h1C000009;
    mem[41] = 32'h00000000;

    rst_n              = 1'b0;
    start              = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Start, folded jump 0 -> 9, backpressure on pc 10
    add(1,1,0,0, 0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0);
    add(0,1,0,0, 1,0,9,0,0);
    add(0,1,0,0, 1,9,10,0,1);
    for (int k = 0; k < 3; k++) add(0,0,0,0, 1,10,11,0,2);
    add(0,1,0,0, 1,10,11,0,2);
    add(0,1,0,0, 1,11,12,0,3);
    add(0,1,0,0, 1,12,13,0,4);
    for (int p = 13; p <= 19; p++) add(0,1,0,0, 1,p,p+1,0,p-8);
    // Redirect while delivering pc 20
    add(0,1,1,15, 1,20,21,0,12);
    add(0,1,0,0,  0,0,15,0,13);
    add(0,1,0,0,  1,15,16,0,13);
    add(0,1,1,32, 1,16,17,0,14);
    add(0,1,0,0,  0,0,32,0,15);
    // 32..40 then halt word at 41; start ignored in HALT
    for (int p = 32; p <= 40; p++) add(0,1,0,0, 1,p,p+1,0,p-17);
    add(1,1,0,0, 0,0,41,1,24);
    add(0,1,1,9, 0,0,41,1,24);
    add(0,1,0,0, 0,0,9,0,24);
    add(0,1,0,0, 1,9,10,0,24);
    // Wrap 62 -> 63 -> 0
    add(0,1,1,62, 1,10,11,0,25);
    add(0,1,0,0,  0,0,62,0,26);
    add(0,1,0,0,  1,62,63,0,26);
    add(0,1,0,0,  1,63,0,0,27);
    add(0,1,1,38, 1,0,9,0,28);
    add(0,1,0,0,  0,0,38,0,29);
    add(0,1,0,0,  1,38,39,0,29);
    add(0,1,0,0,  1,39,40,0,30);
    // Redirect + handshake + halt word presented, all in one cycle
    add(0,1,1,5,  1,40,41,0,31);
    add(0,1,0,0,  0,0,5,0,32);
    add(0,1,0,0,  1,5,6,0,32);
    add(0,1,0,0,  1,6,7,0,33);

    repeat (2) @(negedge clk);
    chk("rst_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count",  32'(fetch_count), 32'd0);
    chk("rst_addr",   32'(bus.imem_addr), 32'd0);
    chk("rst_pc",     32'(bus.out_pc), 32'd0);
    chk("rst_instr",  bus.out_instr, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      start              = vecs[i].st;
      bus.out_ready      = vecs[i].rdy;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      if (vecs[i].e_v && vecs[i].rdy) sb.push_back('{vecs[i].e_pc, mem[vecs[i].e_pc]});
      #1;
      chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_v));
      chk($sformatf("v%0d_addr", i),  32'(bus.imem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].e_h));
      chk($sformatf("v%0d_count", i), 32'(fetch_count), 32'(vecs[i].e_cnt));
      if (vecs[i].e_v) chk($sformatf("v%0d_pc", i), 32'(bus.out_pc), 32'(vecs[i].e_pc));
    end

    // Asynchronous reset while pc 7 is valid
    @(negedge clk);
    start = 1'b0; bus.out_ready = 1'b0; bus.redirect_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_pc",    32'(bus.out_pc), 32'd7);
    chk("pre_rst_count", 32'(fetch_count), 32'd34);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  32'(bus.out_valid), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    chk("mid_rst_count",  32'(fetch_count), 32'd0);
    chk("mid_rst_addr",   32'(bus.imem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores redirect
    @(negedge clk);
    bus.out_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 6'd20;
    @(negedge clk);
    #1;
    chk("idle_rv_addr",  32'(bus.imem_addr), 32'd0);
    chk("idle_rv_valid", 32'(bus.out_valid), 32'd0);
    bus.redirect_valid = 1'b0;

    // Restart: first out_valid two cycles after start
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("restart_addr",  32'(bus.imem_addr), 32'd0);
    chk("restart_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    sb.push_back('{6'd0, mem[0]});
    #1;
    chk("restart_first_valid", 32'(bus.out_valid), 32'd1);
    chk("restart_first_pc",    32'(bus.out_pc), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    #3;
    chk("final_count", 32'(fetch_count), 32'd1);
    chk("sb_drained",  32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
